// File: rtl/vscale_hasti_arbiter_pkg.sv
// Shared HASTI (AHB-Lite) widths, encodings and master indices for the vscale bus arbiter.
// Address/control of a master travels as one packed struct so the grant mux stays a single select.
package vscale_hasti_arbiter_pkg;

   localparam int HASTI_ADDR_WIDTH  = 32;
   localparam int HASTI_BUS_WIDTH   = 32;
   localparam int HASTI_SIZE_WIDTH  = 3;
   localparam int HASTI_BURST_WIDTH = 3;
   localparam int HASTI_PROT_WIDTH  = 4;
   localparam int HASTI_TRANS_WIDTH = 2;
   localparam int HASTI_RESP_WIDTH  = 1;

   localparam logic [HASTI_TRANS_WIDTH-1:0] HASTI_TRANS_IDLE   = 2'd0;
   localparam logic [HASTI_TRANS_WIDTH-1:0] HASTI_TRANS_NONSEQ = 2'd2;
   localparam logic [HASTI_TRANS_WIDTH-1:0] HASTI_TRANS_SEQ    = 2'd3;

   localparam logic [HASTI_RESP_WIDTH-1:0] HASTI_RESP_OKAY  = 1'b0;
   localparam logic [HASTI_RESP_WIDTH-1:0] HASTI_RESP_ERROR = 1'b1;

   localparam logic HASTI_MASTER_IMEM = 1'b0;
   localparam logic HASTI_MASTER_DMEM = 1'b1;

   typedef struct packed {
      logic [HASTI_ADDR_WIDTH-1:0]  haddr;
      logic                         hwrite;
      logic [HASTI_SIZE_WIDTH-1:0]  hsize;
      logic [HASTI_BURST_WIDTH-1:0] hburst;
      logic                         hmastlock;
      logic [HASTI_PROT_WIDTH-1:0]  hprot;
      logic [HASTI_TRANS_WIDTH-1:0] htrans;
   } hasti_ctrl_t;

   function automatic logic hasti_is_req(input logic [HASTI_TRANS_WIDTH-1:0] trans);
      return (trans == HASTI_TRANS_NONSEQ) || (trans == HASTI_TRANS_SEQ);
   endfunction

endpackage

// File: rtl/vscale_rr_arbiter2.sv
// Combinational two-way grant function: hold, single requester, contention (round-robin
// or dmem-priority), then park. Purely combinational, no state.
module vscale_rr_arbiter2
   import vscale_hasti_arbiter_pkg::*;
(
   input  logic [1:0] req,
   input  logic       hold,
   input  logic       held,
   input  logic       last,
   input  logic       mode,
   input  logic       park,
   output logic       grant
);

   always_comb begin
      grant = park;
      if (hold) begin
         grant = held;
      end else begin
         unique case (req)
            2'b01:   grant = HASTI_MASTER_IMEM;
            2'b10:   grant = HASTI_MASTER_DMEM;
            2'b11:   grant = mode ? HASTI_MASTER_DMEM : ~last;
            default: grant = park;
         endcase
      end
   end

endmodule

// File: rtl/vscale_hasti_arbiter.sv
// Two-master (imem/dmem) to one-slave HASTI arbiter with separate address- and data-phase ownership.
// Zero added latency for a winning request; losers are stalled with hready low and hold their address.
module vscale_hasti_arbiter
   import vscale_hasti_arbiter_pkg::*;
#(
   parameter int PRIORITY_MODE = 0,
   parameter int PARK_MASTER   = 0
) (
   input  logic                         clk,
   input  logic                         reset,

   input  logic [HASTI_ADDR_WIDTH-1:0]  imem_haddr,
   input  logic                         imem_hwrite,
   input  logic [HASTI_SIZE_WIDTH-1:0]  imem_hsize,
   input  logic [HASTI_BURST_WIDTH-1:0] imem_hburst,
   input  logic                         imem_hmastlock,
   input  logic [HASTI_PROT_WIDTH-1:0]  imem_hprot,
   input  logic [HASTI_TRANS_WIDTH-1:0] imem_htrans,
   input  logic [HASTI_BUS_WIDTH-1:0]   imem_hwdata,
   output logic [HASTI_BUS_WIDTH-1:0]   imem_hrdata,
   output logic                         imem_hready,
   output logic [HASTI_RESP_WIDTH-1:0]  imem_hresp,

   input  logic [HASTI_ADDR_WIDTH-1:0]  dmem_haddr,
   input  logic                         dmem_hwrite,
   input  logic [HASTI_SIZE_WIDTH-1:0]  dmem_hsize,
   input  logic [HASTI_BURST_WIDTH-1:0] dmem_hburst,
   input  logic                         dmem_hmastlock,
   input  logic [HASTI_PROT_WIDTH-1:0]  dmem_hprot,
   input  logic [HASTI_TRANS_WIDTH-1:0] dmem_htrans,
   input  logic [HASTI_BUS_WIDTH-1:0]   dmem_hwdata,
   output logic [HASTI_BUS_WIDTH-1:0]   dmem_hrdata,
   output logic                         dmem_hready,
   output logic [HASTI_RESP_WIDTH-1:0]  dmem_hresp,

   output logic [HASTI_ADDR_WIDTH-1:0]  hasti_haddr,
   output logic                         hasti_hwrite,
   output logic [HASTI_SIZE_WIDTH-1:0]  hasti_hsize,
   output logic [HASTI_BURST_WIDTH-1:0] hasti_hburst,
   output logic                         hasti_hmastlock,
   output logic [HASTI_PROT_WIDTH-1:0]  hasti_hprot,
   output logic [HASTI_TRANS_WIDTH-1:0] hasti_htrans,
   output logic [HASTI_BUS_WIDTH-1:0]   hasti_hwdata,
   input  logic [HASTI_BUS_WIDTH-1:0]   hasti_hrdata,
   input  logic                         hasti_hready,
   input  logic [HASTI_RESP_WIDTH-1:0]  hasti_hresp
);

   localparam logic PARK = (PARK_MASTER != 0) ? HASTI_MASTER_DMEM : HASTI_MASTER_IMEM;
   localparam logic MODE = (PRIORITY_MODE != 0);

   logic        grant_q;
   logic        last_q;
   logic        dvalid_q;
   logic        downer_q;
   logic        lock_q;

   logic [1:0]  req;
   logic        hold;
   logic        arb_grant;
   logic        grant;
   logic        accept;

   hasti_ctrl_t imem_ctrl;
   hasti_ctrl_t dmem_ctrl;
   hasti_ctrl_t sel_ctrl;

   logic        imem_data_ok;
   logic        imem_addr_ok;
   logic        dmem_data_ok;
   logic        dmem_addr_ok;

   assign req[HASTI_MASTER_IMEM] = hasti_is_req(imem_htrans);
   assign req[HASTI_MASTER_DMEM] = hasti_is_req(dmem_htrans);

   // An unfinished burst or an open locked sequence keeps the bus with its current owner.
   assign hold = lock_q ||
                 (((grant_q == HASTI_MASTER_DMEM) ? dmem_htrans : imem_htrans) == HASTI_TRANS_SEQ);

   vscale_rr_arbiter2 u_arb (
      .req   (req),
      .hold  (hold),
      .held  (grant_q),
      .last  (last_q),
      .mode  (MODE),
      .park  (PARK),
      .grant (arb_grant)
   );

   assign grant = hasti_hready ? arb_grant : grant_q;

   assign imem_ctrl = '{haddr: imem_haddr, hwrite: imem_hwrite, hsize: imem_hsize,
                        hburst: imem_hburst, hmastlock: imem_hmastlock, hprot: imem_hprot,
                        htrans: imem_htrans};
   assign dmem_ctrl = '{haddr: dmem_haddr, hwrite: dmem_hwrite, hsize: dmem_hsize,
                        hburst: dmem_hburst, hmastlock: dmem_hmastlock, hprot: dmem_hprot,
                        htrans: dmem_htrans};
   assign sel_ctrl  = (grant == HASTI_MASTER_DMEM) ? dmem_ctrl : imem_ctrl;

   assign hasti_haddr     = sel_ctrl.haddr;
   assign hasti_hwrite    = sel_ctrl.hwrite;
   assign hasti_hsize     = sel_ctrl.hsize;
   assign hasti_hburst    = sel_ctrl.hburst;
   assign hasti_hmastlock = sel_ctrl.hmastlock;
   assign hasti_hprot     = sel_ctrl.hprot;
   assign hasti_htrans    = reset ? HASTI_TRANS_IDLE : sel_ctrl.htrans;

   assign accept = hasti_hready && hasti_is_req(hasti_htrans);

   assign hasti_hwdata = (downer_q == HASTI_MASTER_DMEM) ? dmem_hwdata : imem_hwdata;
   assign imem_hrdata  = hasti_hrdata;
   assign dmem_hrdata  = hasti_hrdata;

   assign imem_hresp = (dvalid_q && downer_q == HASTI_MASTER_IMEM) ? hasti_hresp : HASTI_RESP_OKAY;
   assign dmem_hresp = (dvalid_q && downer_q == HASTI_MASTER_DMEM) ? hasti_hresp : HASTI_RESP_OKAY;

   // A master is ready only when its own data phase (if any) completes and its address was taken.
   assign imem_data_ok = (dvalid_q && downer_q == HASTI_MASTER_IMEM) ? hasti_hready : 1'b1;
   assign dmem_data_ok = (dvalid_q && downer_q == HASTI_MASTER_DMEM) ? hasti_hready : 1'b1;
   assign imem_addr_ok = !req[HASTI_MASTER_IMEM] || (grant == HASTI_MASTER_IMEM && hasti_hready);
   assign dmem_addr_ok = !req[HASTI_MASTER_DMEM] || (grant == HASTI_MASTER_DMEM && hasti_hready);

   assign imem_hready = !reset && imem_data_ok && imem_addr_ok;
   assign dmem_hready = !reset && dmem_data_ok && dmem_addr_ok;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         grant_q  <= PARK;
         last_q   <= ~PARK;
         dvalid_q <= 1'b0;
         downer_q <= HASTI_MASTER_IMEM;
         lock_q   <= 1'b0;
      end else begin
         grant_q <= grant;
         if (hasti_hready) begin
            if (accept) begin
               dvalid_q <= 1'b1;
               downer_q <= grant;
               last_q   <= grant;
               lock_q   <= hasti_hmastlock;
            end else begin
               dvalid_q <= 1'b0;
               lock_q   <= 1'b0;
            end
         end
      end
   end

endmodule

// File: tb/tb_vscale_hasti_arbiter.sv
// Directed bench: u0 is round-robin/park-imem, u1 is dmem-priority/park-dmem; both share stimulus.
module tb_vscale_hasti_arbiter;
   import vscale_hasti_arbiter_pkg::*;

   logic clk = 1'b0;
   logic reset;
   int   tests = 0;
   int   fails = 0;

   logic [31:0] imem_haddr, dmem_haddr, imem_hwdata, dmem_hwdata, hasti_hrdata;
   logic        imem_hwrite, dmem_hwrite, imem_hmastlock, dmem_hmastlock, hasti_hready;
   logic [2:0]  hsize = 3'd2, hburst = 3'd0;
   logic [3:0]  hprot = 4'd3;
   logic [1:0]  imem_htrans, dmem_htrans;
   logic        hasti_hresp;

   logic [31:0] d0_imem_hrdata, d0_dmem_hrdata, d0_haddr, d0_hwdata;
   logic        d0_imem_hready, d0_dmem_hready, d0_imem_hresp, d0_dmem_hresp;
   logic        d0_hwrite, d0_hmastlock;
   logic [2:0]  d0_hsize, d0_hburst;
   logic [3:0]  d0_hprot;
   logic [1:0]  d0_htrans;
   logic [31:0] d1_imem_hrdata, d1_dmem_hrdata, d1_haddr, d1_hwdata;
   logic        d1_imem_hready, d1_dmem_hready, d1_imem_hresp, d1_dmem_hresp;
   logic        d1_hwrite, d1_hmastlock;
   logic [2:0]  d1_hsize, d1_hburst;
   logic [3:0]  d1_hprot;
   logic [1:0]  d1_htrans;

   always #5 clk = ~clk;

   vscale_hasti_arbiter #(.PRIORITY_MODE(0), .PARK_MASTER(0)) u0 (
      .clk(clk), .reset(reset),
      .imem_haddr(imem_haddr), .imem_hwrite(imem_hwrite), .imem_hsize(hsize), .imem_hburst(hburst),
      .imem_hmastlock(imem_hmastlock), .imem_hprot(hprot), .imem_htrans(imem_htrans),
      .imem_hwdata(imem_hwdata), .imem_hrdata(d0_imem_hrdata), .imem_hready(d0_imem_hready),
      .imem_hresp(d0_imem_hresp),
      .dmem_haddr(dmem_haddr), .dmem_hwrite(dmem_hwrite), .dmem_hsize(hsize), .dmem_hburst(hburst),
      .dmem_hmastlock(dmem_hmastlock), .dmem_hprot(hprot), .dmem_htrans(dmem_htrans),
      .dmem_hwdata(dmem_hwdata), .dmem_hrdata(d0_dmem_hrdata), .dmem_hready(d0_dmem_hready),
      .dmem_hresp(d0_dmem_hresp),
      .hasti_haddr(d0_haddr), .hasti_hwrite(d0_hwrite), .hasti_hsize(d0_hsize),
      .hasti_hburst(d0_hburst), .hasti_hmastlock(d0_hmastlock), .hasti_hprot(d0_hprot),
      .hasti_htrans(d0_htrans), .hasti_hwdata(d0_hwdata), .hasti_hrdata(hasti_hrdata),
      .hasti_hready(hasti_hready), .hasti_hresp(hasti_hresp)
   );

   vscale_hasti_arbiter #(.PRIORITY_MODE(1), .PARK_MASTER(1)) u1 (
      .clk(clk), .reset(reset),
      .imem_haddr(imem_haddr), .imem_hwrite(imem_hwrite), .imem_hsize(hsize), .imem_hburst(hburst),
      .imem_hmastlock(imem_hmastlock), .imem_hprot(hprot), .imem_htrans(imem_htrans),
      .imem_hwdata(imem_hwdata), .imem_hrdata(d1_imem_hrdata), .imem_hready(d1_imem_hready),
      .imem_hresp(d1_imem_hresp),
      .dmem_haddr(dmem_haddr), .dmem_hwrite(dmem_hwrite), .dmem_hsize(hsize), .dmem_hburst(hburst),
      .dmem_hmastlock(dmem_hmastlock), .dmem_hprot(hprot), .dmem_htrans(dmem_htrans),
      .dmem_hwdata(dmem_hwdata), .dmem_hrdata(d1_dmem_hrdata), .dmem_hready(d1_dmem_hready),
      .dmem_hresp(d1_dmem_hresp),
      .hasti_haddr(d1_haddr), .hasti_hwrite(d1_hwrite), .hasti_hsize(d1_hsize),
      .hasti_hburst(d1_hburst), .hasti_hmastlock(d1_hmastlock), .hasti_hprot(d1_hprot),
      .hasti_htrans(d1_htrans), .hasti_hwdata(d1_hwdata), .hasti_hrdata(hasti_hrdata),
      .hasti_hready(hasti_hready), .hasti_hresp(hasti_hresp)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic imem_drv(input logic [1:0] trans, input logic [31:0] addr);
      imem_htrans = trans;
      imem_haddr  = addr;
   endtask

   task automatic dmem_drv(input logic [1:0] trans, input logic [31:0] addr, input logic lock);
      dmem_htrans    = trans;
      dmem_haddr     = addr;
      dmem_hmastlock = lock;
   endtask

   initial begin
      reset = 1'b1;
      imem_hwrite = 1'b0; imem_hmastlock = 1'b0; imem_hwdata = 32'h0;
      dmem_hwrite = 1'b0; dmem_hwdata = 32'h0;
      imem_drv(HASTI_TRANS_NONSEQ, 32'h100);
      dmem_drv(HASTI_TRANS_IDLE, 32'h0, 1'b0);
      hasti_hready = 1'b1; hasti_hresp = HASTI_RESP_OKAY; hasti_hrdata = 32'h0;
      #1;
      chk("rst_htrans", 32'(d0_htrans), 32'(HASTI_TRANS_IDLE));
      chk("rst_imem_hready", 32'(d0_imem_hready), 32'd0);
      chk("rst_dmem_hready", 32'(d0_dmem_hready), 32'd0);
      chk("rst_imem_hresp", 32'(d0_imem_hresp), 32'(HASTI_RESP_OKAY));
      chk("rst_u1_htrans", 32'(d1_htrans), 32'(HASTI_TRANS_IDLE));
      tick(); tick();
      reset = 1'b0;
      #1;
      chk("rel_haddr", d0_haddr, 32'h100);
      chk("rel_htrans", 32'(d0_htrans), 32'(HASTI_TRANS_NONSEQ));
      chk("rel_imem_hready", 32'(d0_imem_hready), 32'd1);
      tick();

      // contention with last = imem: dmem first, then imem
      imem_drv(HASTI_TRANS_NONSEQ, 32'h200);
      dmem_drv(HASTI_TRANS_NONSEQ, 32'h8000, 1'b0);
      hasti_hrdata = 32'h1111_1111;
      #1;
      chk("rr_first_haddr", d0_haddr, 32'h8000);
      chk("rr_imem_stall", 32'(d0_imem_hready), 32'd0);
      chk("rr_dmem_hready", 32'(d0_dmem_hready), 32'd1);
      chk("pri_first_haddr", d1_haddr, 32'h8000);
      tick();
      dmem_drv(HASTI_TRANS_IDLE, 32'h8000, 1'b0);
      hasti_hrdata = 32'hCAFE_F00D;
      #1;
      chk("rr_second_haddr", d0_haddr, 32'h200);
      chk("rr_imem_hready", 32'(d0_imem_hready), 32'd1);
      chk("rd_dmem_hready", 32'(d0_dmem_hready), 32'd1);
      chk("rd_dmem_hrdata", d0_dmem_hrdata, 32'hCAFE_F00D);
      chk("rd_dmem_hresp", 32'(d0_dmem_hresp), 32'(HASTI_RESP_OKAY));
      tick();

      // dmem write stretched by 3 wait states while imem requests
      imem_drv(HASTI_TRANS_IDLE, 32'h200);
      dmem_drv(HASTI_TRANS_NONSEQ, 32'h300, 1'b0);
      dmem_hwrite = 1'b1;
      #1;
      chk("ws_addr", d0_haddr, 32'h300);
      chk("ws_hwrite", 32'(d0_hwrite), 32'd1);
      tick();
      dmem_drv(HASTI_TRANS_IDLE, 32'h300, 1'b0);
      dmem_hwdata = 32'hDEAD_BEEF;
      imem_drv(HASTI_TRANS_NONSEQ, 32'h400);
      hasti_hready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         #1;
         chk("ws_hold_haddr", d0_haddr, 32'h300);
         chk("ws_hold_hwdata", d0_hwdata, 32'hDEAD_BEEF);
         chk("ws_dmem_hready", 32'(d0_dmem_hready), 32'd0);
         chk("ws_imem_hready", 32'(d0_imem_hready), 32'd0);
         tick();
      end
      hasti_hready = 1'b1;
      #1;
      chk("ws_done_dmem_hready", 32'(d0_dmem_hready), 32'd1);
      chk("ws_next_haddr", d0_haddr, 32'h400);
      chk("ws_next_imem_hready", 32'(d0_imem_hready), 32'd1);
      tick();
      dmem_hwrite = 1'b0;

      // locked pair from dmem against continuous imem requests
      imem_drv(HASTI_TRANS_NONSEQ, 32'h500);
      dmem_drv(HASTI_TRANS_NONSEQ, 32'h600, 1'b1);
      #1;
      chk("lk1_haddr", d0_haddr, 32'h600);
      chk("lk1_hmastlock", 32'(d0_hmastlock), 32'd1);
      chk("lk1_imem_hready", 32'(d0_imem_hready), 32'd0);
      tick();
      dmem_drv(HASTI_TRANS_NONSEQ, 32'h604, 1'b1);
      #1;
      chk("lk2_haddr", d0_haddr, 32'h604);
      chk("lk2_imem_hready", 32'(d0_imem_hready), 32'd0);
      tick();
      dmem_drv(HASTI_TRANS_IDLE, 32'h604, 1'b0);
      #1;
      chk("lk_rel_htrans", 32'(d0_htrans), 32'(HASTI_TRANS_IDLE));
      chk("lk_rel_imem_hready", 32'(d0_imem_hready), 32'd0);
      tick();
      dmem_drv(HASTI_TRANS_NONSEQ, 32'h700, 1'b0);
      #1;
      chk("rr_imem_turn", d0_haddr, 32'h500);
      chk("pri_dmem_wins", d1_haddr, 32'h700);
      tick();
      imem_drv(HASTI_TRANS_NONSEQ, 32'h504);
      #1;
      chk("rr_alt_dmem", d0_haddr, 32'h700);
      chk("pri_dmem_wins2", d1_haddr, 32'h700);
      tick();
      dmem_drv(HASTI_TRANS_NONSEQ, 32'h704, 1'b0);
      #1;
      chk("rr_alt_imem", d0_haddr, 32'h504);
      chk("pri_dmem_wins3", d1_haddr, 32'h704);
      tick();

      // reset with a data phase outstanding: no response leaks out
      reset = 1'b1;
      hasti_hresp = HASTI_RESP_ERROR;
      imem_drv(HASTI_TRANS_NONSEQ, 32'h900);
      dmem_drv(HASTI_TRANS_IDLE, 32'hB00, 1'b0);
      #1;
      chk("rst2_imem_hresp", 32'(d0_imem_hresp), 32'(HASTI_RESP_OKAY));
      chk("rst2_dmem_hresp", 32'(d0_dmem_hresp), 32'(HASTI_RESP_OKAY));
      chk("rst2_imem_hready", 32'(d0_imem_hready), 32'd0);
      chk("rst2_htrans", 32'(d0_htrans), 32'(HASTI_TRANS_IDLE));
      tick();
      reset = 1'b0;
      hasti_hresp = HASTI_RESP_OKAY;
      #1;
      chk("err_a_haddr", d0_haddr, 32'h900);
      tick();

      // two-cycle ERROR on imem while dmem waits
      imem_drv(HASTI_TRANS_IDLE, 32'h900);
      dmem_drv(HASTI_TRANS_NONSEQ, 32'hA00, 1'b0);
      hasti_hready = 1'b0;
      hasti_hresp = HASTI_RESP_ERROR;
      #1;
      chk("err1_imem_hresp", 32'(d0_imem_hresp), 32'(HASTI_RESP_ERROR));
      chk("err1_imem_hready", 32'(d0_imem_hready), 32'd0);
      chk("err1_dmem_hresp", 32'(d0_dmem_hresp), 32'(HASTI_RESP_OKAY));
      chk("err1_dmem_hready", 32'(d0_dmem_hready), 32'd0);
      chk("err1_htrans", 32'(d0_htrans), 32'(HASTI_TRANS_IDLE));
      tick();
      hasti_hready = 1'b1;
      #1;
      chk("err2_imem_hresp", 32'(d0_imem_hresp), 32'(HASTI_RESP_ERROR));
      chk("err2_imem_hready", 32'(d0_imem_hready), 32'd1);
      chk("err2_dmem_hresp", 32'(d0_dmem_hresp), 32'(HASTI_RESP_OKAY));
      chk("err2_haddr", d0_haddr, 32'hA00);
      chk("err2_dmem_hready", 32'(d0_dmem_hready), 32'd1);
      tick();

      // idle bus: u1 parks on dmem, u0 on imem
      imem_drv(HASTI_TRANS_IDLE, 32'hC00);
      dmem_drv(HASTI_TRANS_IDLE, 32'hB00, 1'b0);
      dmem_hwrite = 1'b1;
      hasti_hresp = HASTI_RESP_OKAY;
      #1;
      chk("err_after_dmem_hresp", 32'(d0_dmem_hresp), 32'(HASTI_RESP_OKAY));
      chk("err_after_dmem_hready", 32'(d0_dmem_hready), 32'd1);
      chk("park1_haddr", d1_haddr, 32'hB00);
      chk("park1_hwrite", 32'(d1_hwrite), 32'd1);
      chk("park1_htrans", 32'(d1_htrans), 32'(HASTI_TRANS_IDLE));
      chk("park1_imem_hready", 32'(d1_imem_hready), 32'd1);
      chk("park1_dmem_hready", 32'(d1_dmem_hready), 32'd1);
      chk("park0_haddr", d0_haddr, 32'hC00);
      tick();

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/vscale_hasti_arbiter.md
# vscale_hasti_arbiter

Two-master to one-slave HASTI (AHB-Lite) arbiter that lets the vscale core's instruction and data bridges share a single memory port. It sits between `vscale_core`'s imem/dmem bridge outputs and a single-ported SRAM or system bus. It tracks address-phase and data-phase ownership separately, so pipelined transfers from both masters interleave without loss. It uses round-robin or fixed-priority arbitration, parks the bus when idle, and honours `hmastlock` and SEQ bursts.

## Interface
- `PRIORITY_MODE`, default 0. 0 = round-robin on contention; 1 = dmem always wins.
- `PARK_MASTER`, default 0. Master granted when neither requests: 0 = imem, 1 = dmem.
- `clk` in 1. Single clock.
- `reset` in 1. Asynchronous, active-high.
- `imem_*`, `dmem_*` (master side, each):
  - `haddr` in `HASTI_ADDR_WIDTH`
  - `hwrite` in 1
  - `hsize` in `HASTI_SIZE_WIDTH`
  - `hburst` in `HASTI_BURST_WIDTH`
  - `hmastlock` in 1
  - `hprot` in `HASTI_PROT_WIDTH`
  - `htrans` in `HASTI_TRANS_WIDTH`
  - `hwdata` in `HASTI_BUS_WIDTH`
  - `hrdata` out `HASTI_BUS_WIDTH`
  - `hready` out 1
  - `hresp` out `HASTI_RESP_WIDTH`
- `hasti_*` (slave side): the same eleven signals with directions reversed.

## Operation
- **Request.** Master m requests when its `htrans` is NONSEQ or SEQ.
- **Grant.**
  - `grant` is combinational when `hasti_hready` = 1 and equals `grant_q` when `hasti_hready` = 0.
  - `grant_q <= grant` every cycle.
- **Arbitration order** (evaluated only when `hasti_hready` = 1):
  1. Hold `grant_q` if `lock_q` = 1, or if the granted master's `htrans` = SEQ.
  2. Otherwise, if only one master requests, grant it.
  3. Otherwise, if both request:
     - `PRIORITY_MODE` = 0: grant the master other than `last_q`.
     - `PRIORITY_MODE` = 1: grant dmem.
  4. Otherwise (no requests), grant `PARK_MASTER`.
- **Address mux.**
  - `hasti_haddr`, `hwrite`, `hsize`, `hburst`, `hprot`, `hmastlock` and `htrans` come from `grant`.
  - A non-granted master's `htrans` never reaches the slave.
- **Accept.**
  - A transfer is accepted when `hasti_hready` = 1 and `hasti_htrans` is NONSEQ or SEQ.
  - On accept: `dvalid_q <= 1`, `downer_q <= grant`, `last_q <= grant`, `lock_q <= granted hmastlock`.
  - On `hasti_hready` = 1 with no accept: `dvalid_q <= 0`, `lock_q <= 0`.
- **Data mux.**
  - `hasti_hwdata` = `downer_q` master's `hwdata`.
  - `hrdata` is broadcast to both masters.
  - `hresp` = `hasti_hresp` for `downer_q` when `dvalid_q` = 1; OKAY for all other cases.
- **Master `hready`.** `hready_m` = `data_ok_m` & `addr_ok_m`, where:
  - `data_ok_m` = `hasti_hready` if (`dvalid_q` & `downer_q` == m); else 1.
  - `addr_ok_m` = 1 if m is idle; else (`grant` == m & `hasti_hready`).
  - A losing requester therefore sees `hready` = 0 and holds its address (AHB rule), so no address buffering is needed.
- **Error response.**
  - The two-cycle ERROR response is forwarded only to `downer_q`.
  - If the other master is granted during the first ERROR cycle (`hasti_hready` = 0), it stalls.

## Timing
- **Reset values** (while `reset` = 1):
  - `grant_q` = `PARK_MASTER`; `last_q` = 1 − `PARK_MASTER`; `dvalid_q` = 0; `lock_q` = 0.
  - `hasti_htrans` forced IDLE.
  - `imem_hready` = `dmem_hready` = 0; both `hresp` = OKAY.
- **Reset mid-transfer.** An outstanding data phase is dropped, with no response delivered. After deassertion, normal operation begins on the next edge.
- **Latency.**
  - Zero added cycles for an uncontended or winning request: its address appears on `hasti_*` in the same cycle it is presented.
  - A losing request waits exactly one accepted transfer if the winner's transfer is single and unlocked.
- **Stability.** `grant` never changes while `hasti_hready` = 0, so `hasti` address and control are stable through wait states.
- **Simultaneous events.**
  - In the same cycle, the master in data phase (D) and the new grantee (A) may differ. D receives `hready` from the slave; A is accepted together with D's completion.
  - A master may own the data phase and also be granted the next address; back-to-back transfers then run at full rate.
- **Round-robin.** Under continuous contention from both masters, accepted transfers alternate imem/dmem.

## Structure
- Use `vscale_hasti_constants.vh` for `HASTI_TRANS_IDLE/NONSEQ/SEQ`, `HASTI_RESP_OKAY/ERROR` and the widths.
- Add `HASTI_MASTER_IMEM`/`HASTI_MASTER_DMEM` indices there.
- One natural sub-module: `vscale_rr_arbiter2`. It is the combinational two-way grant function: inputs are requests, hold, last and mode; output is grant.
- Registers and muxes stay in the top module.

## Test plan
- **Reset.** Assert `reset` while imem drives NONSEQ at 0x100.
  - During reset: `hasti_htrans` = IDLE and both `hready` = 0.
  - First cycle after release: `hasti_haddr` = 0x100 with NONSEQ.
- **Contention, round-robin.** Both masters issue NONSEQ (imem 0x200, dmem 0x8000) with `last_q` = imem.
  - dmem is accepted first and imem sees `hready` = 0.
  - Next cycle imem 0x200 is accepted.
  - dmem read data is returned only on dmem, with `hresp` OKAY.
- **Wait states.** Slave holds `hready` = 0 for 3 cycles during a dmem write of 0xDEADBEEF.
  - `hasti_haddr`/`hwdata` stay stable and grant does not switch despite a new imem request.
  - `dmem_hready` rises in the cycle the slave `hready` rises.
- **Locked sequence.** dmem issues two transfers with `hmastlock` = 1 while imem requests continuously.
  - Both dmem transfers are accepted consecutively before imem.
  - With `PRIORITY_MODE` = 1, dmem wins every contention.
- **Error response.** Slave returns ERROR on an imem transfer while dmem waits.
  - `imem_hresp` = ERROR for 2 cycles (`hready` 0, then 1).
  - `dmem_hresp` stays OKAY and dmem is accepted after the error completes.
- **Parking.** Idle bus with `PARK_MASTER` = 1: `hasti` control follows dmem, `hasti_htrans` = IDLE, and both `hready` = 1.
